// File: rtl/ft_recovery_sequencer_pkg.sv
// Shared types and default timing constants for the lockstep recovery sequencer.
package ft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HALT    = 3'd1,
      ST_RESET   = 3'd2,
      ST_REPLAY  = 3'd3,
      ST_RESTORE = 3'd4,
      ST_RESUME  = 3'd5,
      ST_FATAL   = 3'd6
   } state_e;

   localparam int DEF_HALT_TIMEOUT = 64;
   localparam int DEF_RESET_CYCLES = 4;

endpackage

// File: rtl/ft_recovery_sequencer.sv
// Lockstep recovery FSM: halt, reset, replay GPR checkpoint, restore PC, resume.
// Outputs are registered Moore decodes (1-cycle input-to-output latency); halted_i is the only handshake.
module ft_recovery_sequencer
   import ft_pkg::*;
#(
   parameter int ADDR_WIDTH   = 5,
   parameter int HALT_TIMEOUT = DEF_HALT_TIMEOUT,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic                  error_i,
   input  logic                  halted_i,
   output logic                  halt_o,
   output logic                  reset_o,
   output logic                  resume_o,
   output logic                  we_sgpr_o,
   output logic                  we_spc_o,
   output logic                  replay_we_o,
   output logic [ADDR_WIDTH-1:0] replay_addr_o,
   output logic                  pc_load_o,
   output logic                  busy_o,
   output logic                  fatal_o,
   output logic [CNT_WIDTH-1:0]  recovery_cnt_o
);

   localparam int TMAX = (HALT_TIMEOUT > RESET_CYCLES) ? HALT_TIMEOUT : RESET_CYCLES;
   localparam int CW   = $clog2(TMAX + 1);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]  rcnt_q, rcnt_d;
   logic halt_q, halt_d, reset_q, reset_d, resume_q, resume_d, we_q, we_d;
   logic replay_we_q, replay_we_d, pc_load_q, pc_load_d, busy_q, busy_d, fatal_q, fatal_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (enable_i && error_i) begin
               state_d = ST_HALT;
               cnt_d   = '0;
            end
         end
         ST_HALT: begin
            // an acknowledge arriving in the last allowed cycle still wins over the timeout
            if (halted_i) begin
               state_d = ST_RESET;
               cnt_d   = '0;
            end else if (cnt_q == CW'(HALT_TIMEOUT - 1)) begin
               state_d = ST_FATAL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESET: begin
            if (cnt_q == CW'(RESET_CYCLES - 1)) begin
               state_d = ST_REPLAY;
               cnt_d   = '0;
               addr_d  = ADDR_WIDTH'(1);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_REPLAY: begin
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
               state_d = ST_RESTORE;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_RESTORE: state_d = ST_RESUME;
         ST_RESUME: begin
            state_d = ST_IDLE;
            if (rcnt_q != {CNT_WIDTH{1'b1}}) rcnt_d = rcnt_q + 1'b1;
         end
         ST_FATAL: state_d = ST_FATAL;
         default:  state_d = ST_IDLE;
      endcase

      // outputs decoded from the next state so they are registered alongside it
      halt_d      = state_d inside {ST_HALT, ST_RESET, ST_REPLAY, ST_RESTORE, ST_FATAL};
      reset_d     = (state_d == ST_RESET);
      resume_d    = (state_d == ST_RESUME);
      we_d        = (state_d == ST_IDLE) && enable_i;
      replay_we_d = (state_d == ST_REPLAY);
      pc_load_d   = (state_d == ST_RESTORE);
      busy_d      = state_d inside {ST_HALT, ST_RESET, ST_REPLAY, ST_RESTORE, ST_RESUME};
      fatal_d     = (state_d == ST_FATAL);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         rcnt_q      <= '0;
         halt_q      <= 1'b0;
         reset_q     <= 1'b0;
         resume_q    <= 1'b0;
         we_q        <= 1'b0;
         replay_we_q <= 1'b0;
         pc_load_q   <= 1'b0;
         busy_q      <= 1'b0;
         fatal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rcnt_q      <= rcnt_d;
         halt_q      <= halt_d;
         reset_q     <= reset_d;
         resume_q    <= resume_d;
         we_q        <= we_d;
         replay_we_q <= replay_we_d;
         pc_load_q   <= pc_load_d;
         busy_q      <= busy_d;
         fatal_q     <= fatal_d;
      end
   end

   assign halt_o         = halt_q;
   assign reset_o        = reset_q;
   assign resume_o       = resume_q;
   assign we_sgpr_o      = we_q;
   assign we_spc_o       = we_q;
   assign replay_we_o    = replay_we_q;
   assign replay_addr_o  = addr_q;
   assign pc_load_o      = pc_load_q;
   assign busy_o         = busy_q;
   assign fatal_o        = fatal_q;
   assign recovery_cnt_o = rcnt_q;

endmodule

// File: tb/tb_ft_recovery_sequencer.sv
// Bench for ft_recovery_sequencer: directed scenarios plus a random soak against a timeline model.
module tb_ft_recovery_sequencer;

   localparam int HT  = 64;
   localparam int RC  = 4;
   localparam int NUM = 32;

   logic clk, rst_n, enable_i, error_i, halted_i;
   logic halt_o, reset_o, resume_o, we_sgpr_o, we_spc_o, replay_we_o, pc_load_o, busy_o, fatal_o;
   logic [4:0] replay_addr_o;
   logic [7:0] recovery_cnt_o;
   logic s_halt, s_reset, s_resume, s_we_sgpr, s_we_spc, s_replay_we, s_pc_load, s_busy, s_fatal;
   logic [4:0] s_addr;
   logic [1:0] s_cnt;

   int checks = 0;
   int errors = 0;

   // model: mode 0 idle, 1 recovering, 2 fatal; t = cycles since halt began, a = t of the acknowledge
   int m_mode = 0, m_t = 0, m_a = -1, m_cnt = 0, m_cnt2 = 0;
   bit m_en = 0;

   ft_recovery_sequencer #(.ADDR_WIDTH(5), .HALT_TIMEOUT(HT), .RESET_CYCLES(RC), .CNT_WIDTH(8)) dut (
      .clk_i(clk), .rst_n(rst_n), .enable_i(enable_i), .error_i(error_i), .halted_i(halted_i),
      .halt_o(halt_o), .reset_o(reset_o), .resume_o(resume_o), .we_sgpr_o(we_sgpr_o),
      .we_spc_o(we_spc_o), .replay_we_o(replay_we_o), .replay_addr_o(replay_addr_o),
      .pc_load_o(pc_load_o), .busy_o(busy_o), .fatal_o(fatal_o), .recovery_cnt_o(recovery_cnt_o)
   );

   ft_recovery_sequencer #(.ADDR_WIDTH(5), .HALT_TIMEOUT(HT), .RESET_CYCLES(RC), .CNT_WIDTH(2)) dut_sat (
      .clk_i(clk), .rst_n(rst_n), .enable_i(enable_i), .error_i(error_i), .halted_i(halted_i),
      .halt_o(s_halt), .reset_o(s_reset), .resume_o(s_resume), .we_sgpr_o(s_we_sgpr),
      .we_spc_o(s_we_spc), .replay_we_o(s_replay_we), .replay_addr_o(s_addr),
      .pc_load_o(s_pc_load), .busy_o(s_busy), .fatal_o(s_fatal), .recovery_cnt_o(s_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      int j;
      if (!rst_n) begin
         m_mode = 0; m_en = 0; m_cnt = 0; m_cnt2 = 0;
         return;
      end
      case (m_mode)
         0: begin
            m_en = enable_i;
            if (enable_i && error_i) begin m_mode = 1; m_t = 0; m_a = -1; end
         end
         1: begin
            if (m_a < 0) begin
               if (halted_i) begin m_a = m_t; m_t++; end
               else if (m_t == HT - 1) m_mode = 2;
               else m_t++;
            end else begin
               j = m_t - m_a;
               if (j == RC + NUM + 1) begin
                  m_mode = 0;
                  m_en = enable_i;
                  if (m_cnt < 255) m_cnt++;
                  if (m_cnt2 < 3) m_cnt2++;
               end else m_t++;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_all();
      int  j;
      bit  rec, post, e_reset, e_replay, e_pc, e_resume, e_halt, e_we;
      int  e_addr;
      rec      = (m_mode == 1);
      post     = rec && (m_a >= 0);
      j        = post ? (m_t - m_a) : 0;
      e_reset  = post && j >= 1 && j <= RC;
      e_replay = post && j >= RC + 1 && j <= RC + NUM - 1;
      e_addr   = e_replay ? (j - RC) : 0;
      e_pc     = post && j == RC + NUM;
      e_resume = post && j == RC + NUM + 1;
      e_halt   = (rec && !e_resume) || (m_mode == 2);
      e_we     = (m_mode == 0) && m_en;
      chk("halt_o", 32'(halt_o), 32'(e_halt));
      chk("reset_o", 32'(reset_o), 32'(e_reset));
      chk("resume_o", 32'(resume_o), 32'(e_resume));
      chk("we_sgpr_o", 32'(we_sgpr_o), 32'(e_we));
      chk("we_spc_o", 32'(we_spc_o), 32'(e_we));
      chk("replay_we_o", 32'(replay_we_o), 32'(e_replay));
      chk("replay_addr_o", 32'(replay_addr_o), 32'(e_addr));
      chk("pc_load_o", 32'(pc_load_o), 32'(e_pc));
      chk("busy_o", 32'(busy_o), 32'(rec));
      chk("fatal_o", 32'(fatal_o), 32'(m_mode == 2));
      chk("recovery_cnt_o", 32'(recovery_cnt_o), 32'(m_cnt));
      chk("sat_recovery_cnt", 32'(s_cnt), 32'(m_cnt2));
      chk("sat_halt", 32'(s_halt), 32'(e_halt));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   // error sampled for one cycle, acknowledge after ack_delay halt cycles; returns halt->resume distance
   task automatic recover(input int ack_delay, input bit noise, output int lat);
      int k;
      lat = -1;
      k = 0;
      enable_i = 1'b1; error_i = 1'b1; halted_i = 1'b0;
      step();
      error_i = 1'b0;
      for (int n = 0; n < 300 && lat < 0; n++) begin
         halted_i = (n >= ack_delay);
         if (noise) begin
            error_i  = 1'($urandom_range(0, 1));
            enable_i = !(n > ack_delay && n <= ack_delay + RC);
         end
         step();
         k++;
         if (resume_o === 1'b1) lat = k;
      end
      error_i = 1'b0; halted_i = 1'b0; enable_i = 1'b1;
      step();
   endtask

   initial begin
      int lat, cnt0, dly;
      rst_n = 1'b0; enable_i = 1'b0; error_i = 1'b0; halted_i = 1'b0;
      repeat (3) step();
      rst_n = 1'b1; enable_i = 1'b1;
      repeat (10) step();
      chk("idle_we_sgpr", 32'(we_sgpr_o), 32'd1);

      // delayed acknowledge: halt lasts 2 cycles
      recover(1, 1'b0, lat);
      chk("latency_ack1", 32'(lat), 32'(2 + RC + (NUM - 1) + 1));
      chk("cnt_after_first", 32'(recovery_cnt_o), 32'd1);

      // immediate acknowledge
      recover(0, 1'b0, lat);
      chk("latency_ack0", 32'(lat), 32'd37);

      // error noise during recovery and enable dropped mid-reset count as one recovery
      cnt0 = int'(recovery_cnt_o);
      recover(0, 1'b1, lat);
      chk("latency_noise", 32'(lat), 32'd37);
      chk("cnt_noise_single", 32'(recovery_cnt_o), 32'(cnt0 + 1));

      // halt timeout leads to sticky fatal
      error_i = 1'b1; halted_i = 1'b0;
      step();
      error_i = 1'b0;
      repeat (HT + 6) step();
      chk("fatal_set", 32'(fatal_o), 32'd1);
      for (int i = 0; i < 12; i++) begin
         error_i  = 1'($urandom_range(0, 1));
         halted_i = 1'($urandom_range(0, 1));
         step();
      end
      chk("fatal_sticky", 32'(fatal_o), 32'd1);
      error_i = 1'b0; halted_i = 1'b0; rst_n = 1'b0;
      step();
      chk("fatal_cleared", 32'(fatal_o), 32'd0);
      rst_n = 1'b1;
      step();

      // five recoveries saturate the 2-bit counter
      for (int r = 0; r < 5; r++) begin
         dly = $urandom_range(0, 5);
         recover(dly, 1'b0, lat);
         chk("latency_rand", 32'(lat), 32'(dly + 1 + RC + (NUM - 1) + 1));
      end
      chk("sat_cnt_3", 32'(s_cnt), 32'd3);
      chk("cnt_5", 32'(recovery_cnt_o), 32'd5);

      // reset in the middle of replay
      error_i = 1'b1; halted_i = 1'b0;
      step();
      error_i = 1'b0; halted_i = 1'b1;
      for (int n = 0; n < 100 && replay_addr_o !== 5'd12; n++) step();
      chk("reached_addr12", 32'(replay_addr_o), 32'd12);
      rst_n = 1'b0; halted_i = 1'b0;
      step();
      chk("rst_addr_zero", 32'(replay_addr_o), 32'd0);
      chk("rst_busy_zero", 32'(busy_o), 32'd0);
      rst_n = 1'b1;
      step();

      // random soak
      for (int c = 0; c < 2000; c++) begin
         rst_n    = ($urandom_range(0, 299) != 0);
         enable_i = ($urandom_range(0, 9) != 0);
         error_i  = ($urandom_range(0, 19) == 0);
         halted_i = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ft_recovery_sequencer.md
Name: ft_recovery_sequencer

Overview:
- Control FSM for the lockstep fault-tolerance datapath (comparator, shared GPR checkpoint, shared PC checkpoint).
- While healthy it gates checkpoint writes.
- On a comparator mismatch it runs the full recovery: halt both cores, reset them, replay the checkpointed register file one register per cycle, restore the PC, then resume.
- Adds a halt-acknowledge timeout, a fatal flag and a saturating recovery counter.

Parameters:
ADDR_WIDTH, 5, register address width; number of registers NUM_REGS = 2**ADDR_WIDTH
HALT_TIMEOUT, 64, maximum cycles to wait for halted_i before declaring fatal
RESET_CYCLES, 4, cycles reset_o is held high
CNT_WIDTH, 8, width of the recovery counter

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
enable_i  in  1  fault tolerance enabled
error_i  in  1  comparator mismatch, combinational, sampled each cycle
halted_i  in  1  both cores report halted
halt_o  out  1  request core halt
reset_o  out  1  core reset pulse
resume_o  out  1  one-cycle resume strobe
we_sgpr_o  out  1  permit GPR checkpoint write
we_spc_o  out  1  permit PC checkpoint write
replay_we_o  out  1  write replay data into both cores' register files
replay_addr_o  out  ADDR_WIDTH  checkpoint read / core write address during replay
pc_load_o  out  1  one-cycle strobe loading the checkpointed PC into both cores
busy_o  out  1  recovery in progress (any state other than IDLE/FATAL)
fatal_o  out  1  sticky unrecoverable fault
recovery_cnt_o  out  CNT_WIDTH  completed recoveries, saturating

Behaviour:
- All outputs are Moore, decoded from registered state and counters. Input-to-output latency is 1 cycle.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; all counters 0; every output 0, including replay_addr_o=0 and recovery_cnt_o=0.
  - Reset mid-recovery aborts immediately to IDLE and clears fatal_o.
- IDLE:
  - we_sgpr_o = we_spc_o = 1 when enable_i=1, else 0.
  - If error_i=1 and enable_i=1, go to HALT. Otherwise stay.
  - With enable_i=0, error_i is ignored.
- HALT:
  - halt_o=1; wait counter increments each cycle.
  - halted_i=1 -> RESET, counter cleared.
  - Otherwise, counter==HALT_TIMEOUT-1 -> FATAL.
  - halted_i takes priority over timeout in the same cycle.
- RESET:
  - reset_o=1 and halt_o=1 for exactly RESET_CYCLES cycles, then go to REPLAY with replay_addr=1.
- REPLAY:
  - halt_o=1; replay_we_o=1; replay_addr_o steps 1,2,...,NUM_REGS-1, one per cycle. x0 is never replayed.
  - After the cycle with addr NUM_REGS-1, go to RESTORE. No wrap to 0.
  - Duration is NUM_REGS-1 cycles.
- RESTORE: halt_o=1; pc_load_o=1 for one cycle; then RESUME.
- RESUME:
  - resume_o=1 for one cycle; halt_o=0.
  - recovery_cnt increments, saturating at 2**CNT_WIDTH-1.
  - Go to IDLE.
- FATAL:
  - fatal_o=1 and halt_o=1, held until rst_n.
  - No checkpoint writes; busy_o=0.
- we_sgpr_o and we_spc_o are 0 in every state except IDLE, so the checkpoint is frozen during recovery.
- error_i is ignored outside IDLE.
- enable_i falling mid-recovery does not abort; the sequence completes.
- error_i in the RESUME cycle is ignored. error_i in the first IDLE cycle after RESUME starts a new recovery.
- Total recovery latency with an immediate halt acknowledge:
  - error at edge T, halt_o at T+1
  - resume_o at T+1+1+RESET_CYCLES+(NUM_REGS-1)+1
  - with defaults: HALT 1 + RESET 4 + REPLAY 31 + RESTORE 1, so resume_o appears 37 cycles after halt_o rises.

Decomposition:
- Package ft_pkg holds:
  - state enum (IDLE, HALT, RESET, REPLAY, RESTORE, RESUME, FATAL), 3-bit encoding;
  - default constants for HALT_TIMEOUT and RESET_CYCLES.
- No sub-module. A single FSM with a shared cycle counter (used for the halt timeout and the reset hold) and the replay address register is natural.
- The saturating counter stays inline.

Test Plan:
- Reset, enable_i=1, no error, 10 cycles -> we_sgpr_o=we_spc_o=1, busy_o=0, all other outputs 0, recovery_cnt_o=0.
- Pulse error_i at cycle 5, halted_i=1 from cycle 7:
  - halt_o rises at cycle 6;
  - reset_o high for 4 cycles;
  - replay_addr_o runs 1..31 with replay_we_o=1;
  - pc_load_o one pulse, then resume_o one pulse;
  - recovery_cnt_o=1; we_sgpr_o=0 throughout.
- error_i with halted_i held 0 -> halt_o held 64 cycles, then fatal_o=1 sticky; later error_i and halted_i have no effect; rst_n=0 clears it.
- error_i re-asserted during REPLAY and enable_i dropped mid-RESET -> sequence unchanged, single recovery counted.
- CNT_WIDTH=2, force 5 recoveries -> recovery_cnt_o saturates at 3.
- rst_n=0 during REPLAY at addr 12 -> next cycle state IDLE, replay_addr_o=0, all outputs 0.
